// File: rtl/uart_chan_sched_pkg.sv
// Shared state encoding and timing derivations for the multi-channel UART scheduler.
package uart_chan_sched_pkg;

   typedef enum logic [2:0] {StIdle, StTx, StTurn, StRx, StGap} state_e;

   function automatic int unsigned bit_cycles(input int unsigned hz, input int unsigned baud);
      return hz / baud;
   endfunction

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   function automatic int unsigned timer_width(input int unsigned turn_bits,
                                               input int unsigned timeout_bits,
                                               input int unsigned gap_bits,
                                               input int unsigned bit_cyc);
      return $clog2(max3(turn_bits, timeout_bits, gap_bits) * bit_cyc + 1);
   endfunction

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_chan_sched_rr_pick.sv
// Round-robin picker: first requesting channel strictly after the last-served index.
module rr_pick #(
   parameter int unsigned N  = 6,
   parameter int unsigned IW = 3
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic          valid,
   output logic [N-1:0]  onehot,
   output logic [IW-1:0] idx
);

   int          pos;
   logic [IW-1:0] p;

   // Scan farthest candidate first so the nearest requester is the last one to win.
   always_comb begin
      valid  = 1'b0;
      onehot = '0;
      idx    = '0;
      pos    = 0;
      p      = '0;
      for (int off = int'(N); off >= 1; off--) begin
         pos = int'(last) + off;
         if (pos >= int'(N)) pos = pos - int'(N);
         p = IW'(pos);
         if (req[p]) begin
            valid     = 1'b1;
            onehot    = '0;
            onehot[p] = 1'b1;
            idx       = p;
         end
      end
   end

endmodule

// File: rtl/uart_chan_sched.sv
// Time-shares one half-duplex UART engine across NUART single-wire driver channels.
module uart_chan_sched
   import uart_chan_sched_pkg::*;
#(
   parameter int unsigned NUART        = 6,
   parameter int unsigned HZ           = 48000000,
   parameter int unsigned BAUD         = 250000,
   parameter int unsigned TURN_BITS    = 4,
   parameter int unsigned TIMEOUT_BITS = 80,
   parameter int unsigned GAP_BITS     = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [NUART-1:0] req,
   input  logic [NUART-1:0] req_reply,
   output logic [NUART-1:0] grant,
   output logic [NUART-1:0] done,
   output logic [NUART-1:0] timeout,
   output logic             eng_start,
   input  logic             eng_tx_done,
   input  logic             eng_rx_done,
   input  logic             eng_tx,
   output logic             eng_rx,
   input  logic [NUART-1:0] uart_in,
   output logic [NUART-1:0] uart_out,
   output logic [NUART-1:0] uart_en
);

   localparam int unsigned BIT_CYCLES = bit_cycles(HZ, BAUD);
   localparam int unsigned TW = timer_width(TURN_BITS, TIMEOUT_BITS, GAP_BITS, BIT_CYCLES);
   localparam int unsigned IW = idx_width(NUART);
   localparam logic [TW-1:0] TURN_LAST    = TW'(TURN_BITS * BIT_CYCLES - 1);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_BITS * BIT_CYCLES - 1);
   localparam logic [TW-1:0] GAP_LAST     = TW'(GAP_BITS * BIT_CYCLES - 1);

   state_e           state_q, state_d;
   logic [TW-1:0]    timer_q, timer_d;
   logic [IW-1:0]    sel_q, sel_d;
   logic             reply_q, reply_d;
   logic [NUART-1:0] grant_q, grant_d;
   logic [NUART-1:0] done_q, done_d;
   logic [NUART-1:0] timeout_q, timeout_d;
   logic             start_q, start_d;

   logic             pick_valid;
   logic [NUART-1:0] pick_onehot;
   logic [IW-1:0]    pick_idx;

   rr_pick #(
      .N  (NUART),
      .IW (IW)
   ) u_rr_pick (
      .req    (req),
      .last   (sel_q),
      .valid  (pick_valid),
      .onehot (pick_onehot),
      .idx    (pick_idx)
   );

   // sel_q doubles as the last-served pointer for the round-robin search.
   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      reply_d   = reply_q;
      grant_d   = grant_q;
      done_d    = '0;
      timeout_d = '0;
      start_d   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (pick_valid) begin
               grant_d = pick_onehot;
               sel_d   = pick_idx;
               reply_d = req_reply[pick_idx];
               start_d = 1'b1;
               state_d = StTx;
            end
         end
         StTx: begin
            if (eng_tx_done) begin
               if (reply_q) begin
                  state_d = StTurn;
               end else begin
                  done_d[sel_q] = 1'b1;
                  state_d       = StGap;
               end
            end
         end
         StTurn: begin
            if (timer_q == TURN_LAST) state_d = StRx;
         end
         StRx: begin
            // A reply landing on the expiry cycle still counts as a reply.
            if (eng_rx_done) begin
               done_d[sel_q] = 1'b1;
               state_d       = StGap;
            end else if (timer_q == TIMEOUT_LAST) begin
               timeout_d[sel_q] = 1'b1;
               state_d          = StGap;
            end
         end
         StGap: begin
            if (timer_q == GAP_LAST) begin
               grant_d = '0;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      if (state_d != state_q) begin
         timer_d = '0;
      end else if (timer_q != '1) begin
         timer_d = timer_q + TW'(1);
      end else begin
         timer_d = timer_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         timer_q   <= '0;
         sel_q     <= IW'(NUART - 1);
         reply_q   <= 1'b0;
         grant_q   <= '0;
         done_q    <= '0;
         timeout_q <= '0;
         start_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         sel_q     <= sel_d;
         reply_q   <= reply_d;
         grant_q   <= grant_d;
         done_q    <= done_d;
         timeout_q <= timeout_d;
         start_q   <= start_d;
      end
   end

   // Pad drive is decoded straight from state so reset releases it without a clock.
   always_comb begin
      uart_en  = '0;
      uart_out = '1;
      eng_rx   = 1'b1;
      if (state_q == StTx) begin
         uart_en[sel_q]  = 1'b1;
         uart_out[sel_q] = eng_tx;
      end
      if (state_q == StRx) begin
         eng_rx = uart_in[sel_q];
      end
   end

   assign grant     = grant_q;
   assign done      = done_q;
   assign timeout   = timeout_q;
   assign eng_start = start_q;

endmodule

// File: tb/tb_uart_chan_sched.sv
// Self-checking bench for uart_chan_sched: vector table, reset/fairness sequences, random traffic.
module tb_uart_chan_sched;

   localparam int unsigned NUART = 6;
   localparam int TURN = 16;
   localparam int TOUT = 320;
   localparam int GAP  = 32;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [NUART-1:0] req = '0;
   logic [NUART-1:0] req_reply = '0;
   logic [NUART-1:0] grant, done, timeout, uart_out, uart_en;
   logic             eng_start, eng_rx;
   logic             eng_tx_done = 1'b0;
   logic             eng_rx_done = 1'b0;
   logic             eng_tx = 1'b1;
   logic [NUART-1:0] uart_in = '1;

   int checks = 0;
   int errors = 0;
   int last_srv = NUART - 1;

   uart_chan_sched #(
      .NUART        (NUART),
      .HZ           (1000000),
      .BAUD         (250000),
      .TURN_BITS    (4),
      .TIMEOUT_BITS (80),
      .GAP_BITS     (8)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .req_reply   (req_reply),
      .grant       (grant),
      .done        (done),
      .timeout     (timeout),
      .eng_start   (eng_start),
      .eng_tx_done (eng_tx_done),
      .eng_rx_done (eng_rx_done),
      .eng_tx      (eng_tx),
      .eng_rx      (eng_rx),
      .uart_in     (uart_in),
      .uart_out    (uart_out),
      .uart_en     (uart_en)
   );

   always #5 clk = ~clk;

   initial begin
      #900000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference picker: first requester at distance 1..NUART after the last-served channel.
   function automatic int model_pick(input logic [NUART-1:0] r, input int last);
      int i;
      for (int off = 1; off <= int'(NUART); off++) begin
         i = (last + off) % int'(NUART);
         if (r[i]) return i;
      end
      return -1;
   endfunction

   // Outcome in cycles after tx_done: reply must arrive while in RX, else timeout at TURN+TOUT.
   function automatic void model_outcome(input logic reply, input int rx_at,
                                         output logic to, output int end_c);
      if (!reply) begin
         to = 1'b0; end_c = 0;
      end else if (rx_at > TURN && rx_at <= TURN + TOUT) begin
         to = 1'b0; end_c = rx_at;
      end else begin
         to = 1'b1; end_c = TURN + TOUT;
      end
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      req = '0; req_reply = '0; eng_tx_done = 1'b0; eng_rx_done = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_grant", grant, 0);
      check("rst_pads", {uart_en, uart_out}, {6'b0, 6'b111111});
      check("rst_misc", {done, timeout, eng_start, eng_rx}, {12'b0, 1'b0, 1'b1});
      rst_n = 1'b1;
      @(negedge clk);
      last_srv = NUART - 1;
   endtask

   // mode 0: req dropped right after grant; 1: served bit dropped at completion; 2: req held.
   task automatic run_txn(input string tag, input logic [NUART-1:0] r,
                          input logic [NUART-1:0] rr, input int tx_len, input int rx_at,
                          input int mode, input logic [NUART-1:0] oh, input logic exp_to,
                          input int exp_end);
      int n, bad, end_c, ch;
      ch = 0;
      for (int i = 0; i < int'(NUART); i++) if (oh[i]) ch = i;
      req = r; req_reply = rr;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (eng_start !== 1'b1 && n < 50);
      check({tag, "_start_lat"}, n, 1);
      check({tag, "_grant"}, grant, oh);
      if (eng_start !== 1'b1) return;
      if (mode == 0) req = '0;
      bad = 0;
      for (int k = 0; k < tx_len; k++) begin
         eng_tx = 1'($urandom);
         #1;
         if (uart_en !== oh || uart_out !== (~oh | (eng_tx ? oh : 6'b0)) || eng_rx !== 1'b1 ||
             (k > 0 && eng_start !== 1'b0) || done !== 0 || grant !== oh) bad++;
         eng_rx_done = (k == 0);
         eng_tx_done = (k == tx_len - 1);
         @(negedge clk);
         eng_tx_done = 1'b0;
         eng_rx_done = 1'b0;
      end
      check({tag, "_tx_phase"}, bad, 0);
      bad = 0;
      end_c = -1;
      for (int c = 0; c <= TURN + TOUT + 20; c++) begin
         if ((done | timeout) !== 0) begin
            end_c = c;
            break;
         end
         uart_in = NUART'($urandom);
         #1;
         if (uart_en !== 0 || uart_out !== '1 || grant !== oh) bad++;
         if (eng_rx !== ((c >= TURN) ? uart_in[ch] : 1'b1)) bad++;
         eng_rx_done = (c == rx_at - 1);
         eng_tx_done = (c == 3);
         @(negedge clk);
         eng_rx_done = 1'b0;
         eng_tx_done = 1'b0;
      end
      check({tag, "_rx_phase"}, bad, 0);
      check({tag, "_end_cycle"}, end_c, exp_end);
      check({tag, "_done"}, done, exp_to ? 6'b0 : oh);
      check({tag, "_timeout"}, timeout, exp_to ? oh : 6'b0);
      if (mode == 1) req[ch] = 1'b0;
      n = 0; bad = 0;
      do begin
         @(negedge clk);
         n++;
         if ((done | timeout | uart_en) !== 0 || eng_start !== 1'b0) bad++;
      end while (grant !== 0 && n < 100);
      check({tag, "_gap_len"}, n, GAP);
      check({tag, "_gap_quiet"}, bad, 0);
   endtask

   typedef struct {
      logic [NUART-1:0] r;
      logic [NUART-1:0] rr;
      int               tx;
      int               rx;
      logic [NUART-1:0] exp_grant;
      logic             exp_to;
      int               exp_end;
   } vec_t;

   vec_t tbl [8];

   initial begin
      logic [NUART-1:0] pend, rr, oh;
      logic             to;
      int               ch, rx, tx, end_c;

      tbl[0] = '{6'b000100, 6'b000000, 10, -1,  6'b000100, 1'b0, 0};
      tbl[1] = '{6'b000010, 6'b000010, 5,  40,  6'b000010, 1'b0, 40};
      tbl[2] = '{6'b000010, 6'b111111, 3,  -1,  6'b000010, 1'b1, 336};
      tbl[3] = '{6'b100000, 6'b100000, 7,  336, 6'b100000, 1'b0, 336};
      tbl[4] = '{6'b000100, 6'b000100, 2,  10,  6'b000100, 1'b1, 336};
      tbl[5] = '{6'b001000, 6'b000000, 1,  -1,  6'b001000, 1'b0, 0};
      tbl[6] = '{6'b011000, 6'b000000, 4,  -1,  6'b010000, 1'b0, 0};
      tbl[7] = '{6'b000011, 6'b000001, 6,  17,  6'b000001, 1'b0, 17};

      @(negedge clk);
      check("init_grant", grant, 0);
      check("init_pads", {uart_en, uart_out}, {6'b0, 6'b111111});
      check("init_misc", {done, timeout, eng_start, eng_rx}, {12'b0, 1'b0, 1'b1});
      do_reset();

      for (int i = 0; i < 8; i++) begin
         run_txn($sformatf("vec%0d", i), tbl[i].r, tbl[i].rr, tbl[i].tx, tbl[i].rx, 0,
                 tbl[i].exp_grant, tbl[i].exp_to, tbl[i].exp_end);
      end

      // All channels requesting continuously: strict rotation from channel 0.
      do_reset();
      for (int i = 0; i < 7; i++) begin
         oh = 6'b000001 << (i % int'(NUART));
         run_txn($sformatf("rot%0d", i), 6'b111111, 6'b0, 3, -1, 2, oh, 1'b0, 0);
      end
      req = '0;

      // Reset in the middle of a channel-3 transmit releases pads with no clock edge.
      do_reset();
      req = 6'b001000;
      @(negedge clk);
      check("rst3_grant", grant, 6'b001000);
      @(negedge clk);
      check("rst3_en_tx", uart_en, 6'b001000);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst3_pads", {uart_en, uart_out}, {6'b0, 6'b111111});
      check("rst3_misc", {grant, done, timeout, eng_start, eng_rx}, {18'b0, 1'b0, 1'b1});
      req = 6'b001001;
      repeat (2) @(negedge clk);
      check("rst3_held", {grant, done, timeout, uart_en}, 24'b0);
      rst_n = 1'b1;
      last_srv = NUART - 1;
      run_txn("rst3_ch0", 6'b001001, 6'b0, 2, -1, 0, 6'b000001, 1'b0, 0);
      run_txn("rst3_ch3", 6'b001000, 6'b0, 2, -1, 0, 6'b001000, 1'b0, 0);

      // Random traffic against the reference model; requests held until served.
      do_reset();
      pend = '0;
      for (int t = 0; t < 20; t++) begin
         pend = pend | NUART'($urandom_range(0, 63));
         if (pend == 0) pend = 6'b000001 << $urandom_range(0, NUART - 1);
         rr = NUART'($urandom);
         tx = $urandom_range(1, 12);
         case ($urandom_range(0, 7))
            0:       rx = -1;
            1:       rx = $urandom_range(1, 16);
            2:       rx = TURN + TOUT;
            default: rx = $urandom_range(17, 60);
         endcase
         ch = model_pick(pend, last_srv);
         oh = 6'b000001 << ch;
         model_outcome(rr[ch], rx, to, end_c);
         run_txn($sformatf("rnd%0d", t), pend, rr, tx, rx, 1, oh, to, end_c);
         last_srv = ch;
         pend = req;
      end
      req = '0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_chan_sched.md
UART_CHAN_SCHED -- requirements
Module: uart_chan_sched

Interface
REQ-001 Parameters SHALL be:
- NUART, default 6: number of single-wire stepper-driver UART channels.
- HZ, default 48000000: clk frequency.
- BAUD, default 250000: driver UART bit rate.
- TURN_BITS, default 4: bus turnaround gap, in bit times.
- TIMEOUT_BITS, default 80: reply timeout, in bit times.
- GAP_BITS, default 8: idle gap after each transaction, in bit times.
REQ-002 Ports SHALL be as follows; the reset is asynchronous and active-low:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUART  channel i requests one transaction.
- req_reply  in  NUART  transaction on channel i expects a reply.
- grant  out  NUART  one-hot owner of the shared engine.
- done  out  NUART  1-cycle pulse; transaction on channel i complete.
- timeout  out  NUART  1-cycle pulse; reply on channel i missed.
- eng_start  out  1  1-cycle pulse; engine begins transmit.
- eng_tx_done  in  1  engine finished transmitting.
- eng_rx_done  in  1  engine received a complete reply.
- eng_tx  in  1  engine serial output.
- eng_rx  out  1  serial input to the engine.
- uart_in  in  NUART  pad input.
- uart_out  out  NUART  pad output value.
- uart_en  out  NUART  pad output enable.

Function
REQ-003 BIT_CYCLES SHALL equal HZ/BAUD (integer division); all timers SHALL count in clk cycles equal to the stated bit count times BIT_CYCLES.
REQ-004 The FSM SHALL have the states IDLE, TX, TURN, RX and GAP.
REQ-005 In IDLE with any req bit set, the block SHALL select the first requesting channel strictly after the last-served channel (round-robin, wrapping NUART-1 to 0), assert grant for it, latch req_reply for it, pulse eng_start on the same clock edge, and enter TX.
REQ-006 In TX, the block SHALL drive uart_en[sel]=1 and uart_out[sel]=eng_tx.
REQ-007 In all states, uart_en SHALL be 0 and uart_out SHALL be 1 on every channel other than the selected channel in TX.
REQ-008 In TX, on eng_tx_done, the block SHALL enter TURN if the latched reply flag is 1; otherwise it SHALL pulse done[sel] and enter GAP.
REQ-009 In TURN, all uart_en SHALL be 0, and the block SHALL enter RX after TURN_BITS*BIT_CYCLES cycles.
REQ-010 In RX, eng_rx SHALL equal uart_in[sel]; in all other states eng_rx SHALL be 1.
REQ-011 In RX, on eng_rx_done, the block SHALL pulse done[sel] and enter GAP.
REQ-012 In RX, if TIMEOUT_BITS*BIT_CYCLES cycles elapse without eng_rx_done, the block SHALL pulse timeout[sel] and enter GAP.
REQ-013 If eng_rx_done and timer expiry occur in the same cycle, eng_rx_done SHALL win: done pulses and timeout does not.
REQ-014 In GAP, grant SHALL remain held; after GAP_BITS*BIT_CYCLES cycles, the block SHALL clear grant and return to IDLE.
REQ-015 The earliest new grant SHALL occur on the cycle after the block enters IDLE.
REQ-016 Deassertion of req mid-transaction SHALL be ignored; the transaction SHALL run to done or timeout.
REQ-017 The requester SHALL hold req until it sees its done or timeout pulse; the block SHALL NOT serve the same channel twice in a row while another channel requests.
REQ-018 eng_tx_done or eng_rx_done arriving in any state other than the one that consumes it SHALL be ignored.
REQ-019 The shared timer SHALL be $clog2(max(TURN_BITS,TIMEOUT_BITS,GAP_BITS)*BIT_CYCLES+1) bits wide, SHALL clear on every state entry, and SHALL never wrap.

Reset
REQ-020 While rst_n=0, the block SHALL immediately (asynchronously) force: FSM=IDLE, grant=0, done=0, timeout=0, eng_start=0, eng_rx=1, uart_en=0, uart_out=all ones.
REQ-021 Reset SHALL set the last-served pointer to NUART-1, so channel 0 is served first.
REQ-022 A reset during any state SHALL release the pad drive within the reset assertion and SHALL emit no done or timeout pulse.

Structure
REQ-023 The FSM state encoding and the BIT_CYCLES/timer-width derivation SHALL live in the shared conan package/include.
REQ-024 Round-robin selection SHALL be a sub-module rr_pick (inputs: req vector and last index; outputs: valid and one-hot/index).

Verification
Bench parameters: HZ=1000000, BAUD=250000, so BIT_CYCLES=4; TURN=16, TIMEOUT=320 and GAP=32 cycles.
REQ-025 req=6'b000100, req_reply=0, eng_tx_done 10 cycles after eng_start -> grant=000100, uart_en[2]=1 for 10 cycles, done[2] pulse, grant clears 32 cycles later.
REQ-026 req[1] set with req_reply[1]=1, eng_tx_done, then eng_rx_done 40 cycles later -> uart_en all 0 from tx_done, eng_rx follows uart_in[1] starting 16 cycles after tx_done, done[1] pulse.
REQ-027 Reply expected and no eng_rx_done -> timeout[1] pulses exactly 320 cycles after RX entry; done[1] never pulses.
REQ-028 req=6'b111111 held continuously -> grants in order 0,1,2,3,4,5,0; each grant is followed by a 32-cycle gap.
REQ-029 eng_rx_done coincident with the timeout cycle -> done pulses, timeout stays 0.
REQ-030 rst_n low mid-TX on channel 3 -> uart_en=0 and uart_out=all ones with no clk edge; after release, req[3] is served first only if channel 0 is not requesting.
